// File: rtl/div23_seq_ctrl.sv
// Sequential constant divider: walks the dividend MSB-first CHUNK bits per step, carrying a running remainder.
// Optional macro DIV23_BACK2BACK_EN lets DONE accept the next dividend in the same edge as the output handshake.
module div23_seq_ctrl #(
    parameter int WIDTH   = 16,
    parameter int CHUNK   = 4,
    parameter int DIVISOR = 23,
    localparam int RW     = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [RW-1:0]    out_rem,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("div23_seq_ctrl: WIDTH must be a multiple of CHUNK");
        end
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("div23_seq_ctrl: DIVISOR must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] quot;
    logic [RW-1:0]    rem;
    logic [CHUNK-1:0] digit;
    logic [RW-1:0]    rem_nxt;

    // One digit stage: restoring division of {rem, dig_in} by DIVISOR.
    // rem < DIVISOR on entry keeps every partial value below 2*DIVISOR, so RW+1 bits suffice.
    function automatic logic [CHUNK+RW-1:0] digit_step(input logic [RW-1:0]    rem_in,
                                                      input logic [CHUNK-1:0] dig_in);
        logic [RW:0]      r;
        logic [CHUNK-1:0] q;
        r = {1'b0, rem_in};
        q = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            r = {r[RW-1:0], dig_in[CHUNK-1-i]};
            if (r >= (RW+1)'(DIVISOR)) begin
                r = r - (RW+1)'(DIVISOR);
                q[CHUNK-1-i] = 1'b1;
            end
        end
        return {q, r[RW-1:0]};
    endfunction

    always_comb begin
        {digit, rem_nxt} = digit_step(rem, shreg[WIDTH-1 -: CHUNK]);
    end

    always_comb begin
        in_ready = (state == IDLE);
`ifdef DIV23_BACK2BACK_EN
        if (state == DONE && out_ready)
            in_ready = 1'b1;
`endif
    end

    assign out_quot = quot;
    assign out_rem  = rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            quot      <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        quot  <= '0;
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    quot  <= (quot << CHUNK) | WIDTH'(digit);
                    rem   <= rem_nxt;
                    shreg <= shreg << CHUNK;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
`ifdef DIV23_BACK2BACK_EN
                        if (in_valid) begin
                            shreg <= in_data;
                            quot  <= '0;
                            rem   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/div23_seq_ctrl.md
Name: div23_seq_ctrl

Overview:
- Sequential controller for unsigned constant division by DIVISOR (default 23).
- Walks a WIDTH-bit dividend MSB-first in CHUNK-bit digits and carries a running remainder between steps; each step uses one digit-quotient/remainder stage of the same form as the per-digit quotient LUTs.
- Sits between a producer and consumer with valid/ready handshakes on both sides.
- Returns the full quotient and the final remainder.

Parameters:
- WIDTH, 16, dividend and quotient width. WIDTH % CHUNK must be 0; elaboration fails otherwise.
- CHUNK, 4, dividend bits consumed per step. Also the quotient digit width.
- DIVISOR, 23, constant divisor. Must be ≥ 2 and < 2^CHUNK·DIVISOR-safe; the default needs no check.
- RW, $clog2(DIVISOR) = 5, remainder width (derived localparam, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  dividend offered
- in_ready  out  1  controller can accept a dividend
- in_data  in  WIDTH  dividend
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_quot  out  WIDTH  quotient = in_data / DIVISOR
- out_rem  out  RW  remainder = in_data % DIVISOR
- busy  out  1  high in RUN

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE, step count=0, dividend shift register=0, quotient register=0, remainder register=0.
  - in_ready=1, out_valid=0, out_quot=0, out_rem=0, busy=0.
  - Reset asserted mid-RUN or in DONE aborts the operation; the pending result is discarded.
- N = WIDTH/CHUNK steps (default 4).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready edge: load shift register with in_data, clear rem and quotient, count=0, go to RUN.
- RUN:
  - in_ready=0, busy=1. Each edge performs one step:
    - t = rem·2^CHUNK + top CHUNK bits of shift register. Since t < DIVISOR·2^CHUNK, the digit fits in CHUNK bits.
    - digit = t / DIVISOR; rem ← t % DIVISOR.
    - quotient ← (quotient << CHUNK) | digit.
    - Shift register ← shift register << CHUNK.
    - count++.
  - On the step where count == N-1: go to DONE.
- Latency: out_valid rises exactly N edges after the accepting edge (4 for defaults).
- DONE:
  - out_valid=1; out_quot and out_rem are stable and held until the handshake.
  - in_ready=0 unless the optional feature below is enabled.
  - On out_valid&out_ready edge: go to IDLE (or see the optional feature); out_valid drops.
- Back-pressure: out_ready=0 holds DONE indefinitely; values must not change.
- in_valid during RUN or DONE is ignored (not accepted). The producer must hold in_valid and in_data until in_ready.
- out_quot/out_rem registered outputs. They may show partial values during RUN; they are only meaningful while out_valid=1.
- Throughput without the optional feature: one result per N+2 cycles maximum.

Optional Feature:
- Macro: DIV23_BACK2BACK_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - An edge with out_valid&out_ready&in_valid both completes the output handshake and loads the new dividend, going directly DONE→RUN.
  - Sustained throughput is one result per N+1 cycles.
  - If out_ready=1 but in_valid=0, go to IDLE as normal.
- Undefined:
  - in_ready=0 in DONE. DONE→IDLE always takes one cycle before the next accept.

Test Plan:
- Reset then in_data=65535 -> out_valid 4 edges after accept, out_quot=2849, out_rem=8, busy high for exactly 4 cycles.
- in_data=1000, 22, 23, 0 sequentially with out_ready=1 -> quot/rem 43/11, 0/22, 1/0, 0/0. Without the macro, in_ready is low for one cycle after each output handshake.
- in_data=46 with out_ready held 0 for 10 cycles -> out_valid stays 1, out_quot=2, out_rem=0 stable. in_valid pulses during that time are not accepted.
- rst asserted on the 2nd RUN cycle of in_data=500 -> next cycle IDLE, out_valid=0, outputs 0. Then in_data=500 -> out_quot=21, out_rem=17.
- With DIV23_BACK2BACK_EN, in_valid=1 and out_ready=1 continuously for dividends 100, 200, 300 -> results 4/8, 8/16, 13/1 spaced 5 cycles apart; no IDLE cycle between them.
- Random sweep of 10k dividends across 0..65535 -> every result matches the integer reference: quot·23 + rem == dividend, rem < 23.
